// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared encodings and helpers for the AHB bus-matrix output stage.
//
// Contents:
//   htrans_e      AHB transfer type encodings (IDLE, BUSY, NONSEQ, SEQ).
//   hburst_e      AHB burst type encodings (SINGLE .. INCR16).
//   REMAIN_W      width of the burst beat-remaining counter.
//   burst_remain  beats still to be held after the NONSEQ beat of a burst.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'b000,
        BurstIncr   = 3'b001,
        BurstWrap4  = 3'b010,
        BurstIncr4  = 3'b011,
        BurstWrap8  = 3'b100,
        BurstIncr8  = 3'b101,
        BurstWrap16 = 3'b110,
        BurstIncr16 = 3'b111
    } hburst_e;

    localparam int unsigned REMAIN_W = 4;

    // Value loaded on the NONSEQ beat. Hold drops on the SEQ that finds the
    // count already at zero, i.e. on the final beat of a fixed-length burst.
    function automatic logic [REMAIN_W-1:0] burst_remain(input hburst_e burst);
        logic [REMAIN_W-1:0] remain;
        case (burst)
            BurstWrap4, BurstIncr4:   remain = REMAIN_W'(2);
            BurstWrap8, BurstIncr8:   remain = REMAIN_W'(6);
            BurstWrap16, BurstIncr16: remain = REMAIN_W'(14);
            BurstIncr:                remain = REMAIN_W'(2);
            default:                  remain = '0;
        endcase
        return remain;
    endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// ahb_mtx_rr_pick: combinational rotating picker.
//
// Searches mask_i starting at index start_i, wrapping modulo NUM_PORTS, and
// returns the first set position.
//
// Ports:
//   mask_i   [NUM_PORTS-1:0]  candidate set
//   start_i  [PORT_W-1:0]     first index examined
//   valid_o                   at least one candidate found
//   idx_o    [PORT_W-1:0]     index of the chosen candidate (0 when none)
module ahb_mtx_rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] mask_i,
    input  logic [PORT_W-1:0]    start_i,
    output logic                 valid_o,
    output logic [PORT_W-1:0]    idx_o
);

    logic [PORT_W-1:0] pos;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            pos = PORT_W'((32'(start_i) + k) % NUM_PORTS);
            if (!valid_o && mask_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_qos_arbiter.sv
// ahb_mtx_qos_arbiter: output-stage arbiter for the AHB bus matrix.
//
// Shares one slave port among NUM_PORTS input stages with burst-aware and
// lock-aware rotating priority, a static high-priority class and, when the
// QOS_STARVE_EN macro is defined, anti-starvation escalation via per-port wait
// counters. Without QOS_STARVE_EN, starve_flag is tied low and STARVE_LIMIT /
// CNT_W have no effect.
//
// Ports:
//   HCLK          clock, all state on the rising edge
//   HRESET        synchronous active-high reset
//   req_port      per-port request
//   prio_port     per-port high-priority class flag
//   HREADYM       output transfer done; gates every state update
//   HSELM         output slave select
//   HTRANSM       output transfer type
//   HBURSTM       output burst type
//   HMASTLOCKM    output locked transfer
//   addr_in_port  selected input port (registered)
//   no_port       no input port selected (registered)
//   starve_flag   per-port escalation status (registered)
module ahb_mtx_qos_arbiter
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned PORT_W       = 2,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic [NUM_PORTS-1:0] prio_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [NUM_PORTS-1:0] starve_flag
);

    htrans_e trans;
    hburst_e burst;

    assign trans = htrans_e'(HTRANSM);
    assign burst = hburst_e'(HBURSTM);

    // ------------------------------------------------------------------
    // Burst hold tracking
    // ------------------------------------------------------------------
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic                hold_q, hold_d;
    logic [1:0]          incr_cnt_q, incr_cnt_d;

    always_comb begin
        remain_d = remain_q;
        hold_d   = hold_q;
        if (!HSELM) begin
            remain_d = '0;
            hold_d   = 1'b0;
        end else begin
            unique case (trans)
                TransNonseq: begin
                    if (burst == BurstSingle) begin
                        remain_d = '0;
                        hold_d   = 1'b0;
                    end else if (burst == BurstIncr) begin
                        // Back-to-back short INCR bursts give up the bus early.
                        remain_d = burst_remain(burst);
                        hold_d   = (incr_cnt_q != 2'd1);
                    end else begin
                        remain_d = burst_remain(burst);
                        hold_d   = 1'b1;
                    end
                end
                TransSeq: begin
                    if (remain_q == '0) begin
                        hold_d = 1'b0;
                    end else begin
                        remain_d = remain_q - REMAIN_W'(1);
                    end
                end
                TransBusy: begin
                    remain_d = remain_q;
                    hold_d   = hold_q;
                end
                TransIdle: begin
                    remain_d = '0;
                    hold_d   = 1'b0;
                end
                default: begin
                    remain_d = '0;
                    hold_d   = 1'b0;
                end
            endcase
        end

        incr_cnt_d = incr_cnt_q;
        if (!hold_d) begin
            incr_cnt_d = '0;
        end else if (trans == TransNonseq && hold_q) begin
            incr_cnt_d = incr_cnt_q + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Wait counters / escalation
    // ------------------------------------------------------------------
    logic [PORT_W-1:0]    addr_q, addr_d;
    logic                 no_port_q, no_port_d;
    logic [NUM_PORTS-1:0] starve;

`ifdef QOS_STARVE_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] wait_q, wait_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            starve[i] = (wait_q[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // A port stops waiting once it is either the current or the new grant.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_port[i] || (!no_port_q && addr_q == PORT_W'(i)) ||
                (!no_port_d && addr_d == PORT_W'(i))) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != CNT_W'(STARVE_LIMIT)) begin
                wait_d[i] = wait_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_q <= '0;
        end else if (HREADYM) begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_cfg;

    assign starve     = '0;
    assign unused_cfg = (STARVE_LIMIT == CNT_W);
`endif

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [PORT_W-1:0] start_ptr;
    logic              esc_valid, prio_valid, any_valid;
    logic [PORT_W-1:0] esc_idx, prio_idx, any_idx;

    // Start one past the current grant so the current port is checked last.
    always_comb begin
        if (no_port_q || addr_q == PORT_W'(NUM_PORTS - 1)) begin
            start_ptr = '0;
        end else begin
            start_ptr = addr_q + PORT_W'(1);
        end
    end

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick_esc (
        .mask_i  (req_port & starve),
        .start_i (start_ptr),
        .valid_o (esc_valid),
        .idx_o   (esc_idx)
    );

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick_prio (
        .mask_i  (req_port & prio_port),
        .start_i (start_ptr),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    ahb_mtx_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick_any (
        .mask_i  (req_port),
        .start_i (start_ptr),
        .valid_o (any_valid),
        .idx_o   (any_idx)
    );

    always_comb begin
        addr_d    = addr_q;
        no_port_d = no_port_q;
        // Lock and burst hold beat escalation: the grant never moves mid-burst.
        if (!HMASTLOCKM && !hold_d) begin
            if (esc_valid) begin
                addr_d    = esc_idx;
                no_port_d = 1'b0;
            end else if (prio_valid) begin
                addr_d    = prio_idx;
                no_port_d = 1'b0;
            end else if (any_valid) begin
                addr_d    = any_idx;
                no_port_d = 1'b0;
            end else if (!HSELM) begin
                no_port_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            remain_q   <= '0;
            hold_q     <= 1'b0;
            incr_cnt_q <= '0;
            addr_q     <= '0;
            no_port_q  <= 1'b1;
        end else if (HREADYM) begin
            remain_q   <= remain_d;
            hold_q     <= hold_d;
            incr_cnt_q <= incr_cnt_d;
            addr_q     <= addr_d;
            no_port_q  <= no_port_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign starve_flag  = starve;

endmodule

// File: tb/tb_ahb_mtx_qos_arbiter.sv
// Self-checking bench for ahb_mtx_qos_arbiter (NUM_PORTS=4, STARVE_LIMIT=16).
// Works with and without QOS_STARVE_EN defined.
module tb_ahb_mtx_qos_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, INC4 = 3'b011;
    localparam logic [2:0] WRP8 = 3'b100, INC8 = 3'b101, INC16 = 3'b111;

`ifdef QOS_STARVE_EN
    localparam bit QOS = 1'b1;
`else
    localparam bit QOS = 1'b0;
`endif

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req_port, prio_port;
    logic       HREADYM, HSELM, HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic [3:0] starve_flag;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] prio;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic [1:0] exp_addr;
        logic       exp_nop;
    } vec_t;

    vec_t vecs[$];

    ahb_mtx_qos_arbiter #(
        .NUM_PORTS    (4),
        .PORT_W       (2),
        .STARVE_LIMIT (16),
        .CNT_W        (5)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_port     (req_port),
        .prio_port    (prio_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .starve_flag  (starve_flag)
    );

    always #5 HCLK = ~HCLK;

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] prio,
                                input logic rdy, input logic sel, input logic [1:0] trans,
                                input logic [2:0] burst, input logic lock,
                                input logic [1:0] ea, input logic en);
        vec_t v;
        v.rst = rst; v.req = req; v.prio = prio; v.rdy = rdy; v.sel = sel;
        v.trans = trans; v.burst = burst; v.lock = lock; v.exp_addr = ea; v.exp_nop = en;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] prio,
                         input logic rdy, input logic sel, input logic [1:0] trans,
                         input logic [2:0] burst, input logic lock);
        HRESET = rst; req_port = req; prio_port = prio; HREADYM = rdy; HSELM = sel;
        HTRANSM = trans; HBURSTM = burst; HMASTLOCKM = lock;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] ea, input logic en,
                         input logic [3:0] es);
        n_vec++;
        if (addr_in_port !== ea || no_port !== en || starve_flag !== es) begin
            n_miss++;
            $display("FAIL %s: got addr=%0d no_port=%b starve=%b, want addr=%0d no_port=%b starve=%b",
                     name, addr_in_port, no_port, starve_flag, ea, en, es);
        end
    endtask

    initial begin
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        step();
        step();

        //   rst  req      prio     rdy   sel   trans burst lock  addr  nop
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b1); // 0 reset
        add(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 1 from port 0
        add(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd2, 1'b0); // 2 rotate
        add(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 3 wrap
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b1); // 4 no req
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 5
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 6 keep, HSELM
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 7
        add(1'b0, 4'b1011, 4'b1000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd3, 1'b0); // 8 prio wins
        add(1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 9
        add(1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 10
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 11
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, NSEQ, INC8, 1'b0, 2'd0, 1'b0); // 12 INCR8 beat 1
        for (int b = 2; b <= 7; b++)
            add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, SEQ, INC8, 1'b0, 2'd0, 1'b0); // 13-18
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, SEQ,  INC8, 1'b0, 2'd1, 1'b0); // 19 beat 8
        add(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 20 frozen
        add(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 21 frozen
        add(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, IDLE, SGL,  1'b0, 2'd2, 1'b0); // 22
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, NSEQ, SGL,  1'b1, 2'd2, 1'b0); // 23 locked
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, NSEQ, SGL,  1'b1, 2'd2, 1'b0); // 24 locked
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, IDLE, SGL,  1'b0, 2'd0, 1'b0); // 25 unlock
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, NSEQ, INC4, 1'b0, 2'd0, 1'b0); // 26 INCR4
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, BUSY, INC4, 1'b0, 2'd0, 1'b0); // 27 BUSY
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, SEQ,  INC4, 1'b0, 2'd0, 1'b0); // 28
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, SEQ,  INC4, 1'b0, 2'd0, 1'b0); // 29
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, SEQ,  INC4, 1'b0, 2'd3, 1'b0); // 30 last beat
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, NSEQ, INC,  1'b0, 2'd3, 1'b0); // 31 INCR hold
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, NSEQ, INC,  1'b0, 2'd3, 1'b0); // 32 count->1
        add(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, NSEQ, INC,  1'b0, 2'd0, 1'b0); // 33 early rel
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, NSEQ, INC16, 1'b0, 2'd0, 1'b0); // 34
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, IDLE, SGL,  1'b0, 2'd1, 1'b0); // 35 IDLE drop
        add(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, NSEQ, WRP8, 1'b0, 2'd1, 1'b0); // 36
        add(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, SEQ,  WRP8, 1'b0, 2'd2, 1'b0); // 37 HSELM=0
        add(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, NSEQ, INC16, 1'b0, 2'd2, 1'b0); // 38 INCR16
        for (int b = 2; b <= 4; b++)
            add(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, SEQ, INC16, 1'b0, 2'd2, 1'b0); // 39-41
        add(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b1, SEQ,  INC16, 1'b0, 2'd0, 1'b1); // 42 reset b5
        add(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, NSEQ, SGL,  1'b0, 2'd3, 1'b0); // 43

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].prio, vecs[i].rdy, vecs[i].sel,
                  vecs[i].trans, vecs[i].burst, vecs[i].lock);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_nop, 4'b0000);
        end

        // Starvation: port 0 high priority, port 1 waits 16 ready cycles.
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        step();
        drive(1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("starve_wait", 2'd0, 1'b0, 4'b0000);
        end
        drive(1'b0, 4'b0010, 4'b0001, 1'b0, 1'b0, IDLE, SGL, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("starve_freeze", 2'd0, 1'b0, 4'b0000);
        end
        drive(1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        for (int k = 9; k <= 15; k++) begin
            step();
            check("starve_wait2", 2'd0, 1'b0, 4'b0000);
        end
        step();
        check("starve_rise", 2'd0, 1'b0, QOS ? 4'b0010 : 4'b0000);
        step();
        check("starve_grant", QOS ? 2'd1 : 2'd0, 1'b0, 4'b0000);
        step();
        check("starve_after", 2'd0, 1'b0, 4'b0000);

        // Lock holds the grant while port 2 escalates.
        drive(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        step();
        drive(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, IDLE, SGL, 1'b0);
        step();
        check("lock_pre", 2'd0, 1'b0, 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, NSEQ, SGL, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step();
            check("lock_hold", 2'd0, 1'b0, 4'b0000);
        end
        HREADYM = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("lock_freeze", 2'd0, 1'b0, 4'b0000);
        end
        HREADYM = 1'b1;
        step();
        check("lock_escalate", 2'd0, 1'b0, QOS ? 4'b0100 : 4'b0000);
        step();
        check("lock_saturate", 2'd0, 1'b0, QOS ? 4'b0100 : 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b1, IDLE, SGL, 1'b0);
        step();
        check("lock_release", 2'd2, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
